// File: rtl/button_conditioner_pkg.sv
// Shared FSM state encodings and default timing constants for the button conditioner.
// Default timings assume a 100 MHz CLK.
package button_conditioner_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE     = 2'd0;
  localparam state_t ST_DB_PRESS = 2'd1;
  localparam state_t ST_DOWN     = 2'd2;
  localparam state_t ST_DB_REL   = 2'd3;

  localparam int DEF_N_BTN       = 5;
  localparam int DEF_DB_CYCLES   = 1_000_000;
  localparam int DEF_HOLD_CYCLES = 50_000_000;
  localparam int DEF_RPT_CYCLES  = 10_000_000;

endpackage

// File: rtl/button_conditioner_btn_channel.sv
// One button: 2-flop synchronizer, debounce FSM, and hold/auto-repeat timer.
// Latency: press/release pulses DB_CYCLES+3 edges after the raw change; no backpressure, pulses are not held.
module btn_channel
  import button_conditioner_pkg::*;
#(
  parameter int DB_CYCLES   = DEF_DB_CYCLES,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int RPT_CYCLES  = DEF_RPT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic lvl,
  output logic press,
  output logic rel,
  output logic rpt
);

  localparam int DBW  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int HMAX = (HOLD_CYCLES > RPT_CYCLES) ? HOLD_CYCLES : RPT_CYCLES;
  localparam int HW   = $clog2(HMAX);

  localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
  localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0]  RPT_LAST  = HW'(RPT_CYCLES - 1);

  logic           sync_q1;
  logic           sync_q2;
  state_t         state;
  state_t         state_d;
  logic [DBW-1:0] db_cnt;
  logic [DBW-1:0] db_cnt_d;
  logic [HW-1:0]  hold_cnt;
  logic [HW-1:0]  hold_last;
  logic           rpt_phase;
  logic           enter_down;
  logic           enter_idle;
  logic           holding;
  logic           rpt_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
    end
  end

  always_comb begin
    state_d    = state;
    db_cnt_d   = db_cnt;
    enter_down = 1'b0;
    enter_idle = 1'b0;
    case (state)
      ST_IDLE: begin
        if (sync_q2) begin
          state_d  = ST_DB_PRESS;
          db_cnt_d = '0;
        end
      end
      ST_DB_PRESS: begin
        if (!sync_q2) begin
          state_d = ST_IDLE;
        end else if (db_cnt == DB_LAST) begin
          state_d    = ST_DOWN;
          enter_down = 1'b1;
        end else begin
          db_cnt_d = db_cnt + DBW'(1);
        end
      end
      ST_DOWN: begin
        if (!sync_q2) begin
          state_d  = ST_DB_REL;
          db_cnt_d = '0;
        end
      end
      ST_DB_REL: begin
        if (sync_q2) begin
          state_d = ST_DOWN;
        end else if (db_cnt == DB_LAST) begin
          state_d    = ST_IDLE;
          enter_idle = 1'b1;
        end else begin
          db_cnt_d = db_cnt + DBW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A release that completes on the same edge as a repeat wins, keeping the pulses exclusive.
  assign holding   = (state == ST_DOWN) || (state == ST_DB_REL);
  assign hold_last = rpt_phase ? RPT_LAST : HOLD_LAST;
  assign rpt_fire  = holding && !enter_idle && (hold_cnt == hold_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      db_cnt    <= '0;
      hold_cnt  <= '0;
      rpt_phase <= 1'b0;
      lvl       <= 1'b0;
      press     <= 1'b0;
      rel       <= 1'b0;
      rpt       <= 1'b0;
    end else begin
      state  <= state_d;
      db_cnt <= db_cnt_d;
      press  <= enter_down;
      rel    <= enter_idle;
      rpt    <= rpt_fire;
      if (enter_down) begin
        lvl <= 1'b1;
      end else if (enter_idle) begin
        lvl <= 1'b0;
      end
      if (enter_down) begin
        hold_cnt  <= '0;
        rpt_phase <= 1'b0;
      end else if (holding) begin
        if (hold_cnt == hold_last) begin
          hold_cnt  <= '0;
          rpt_phase <= 1'b1;
        end else begin
          hold_cnt <= hold_cnt + HW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// N_BTN independent debounced button channels with press/release/auto-repeat pulses.
// Latency: DB_CYCLES+3 edges from raw change to pulse; no backpressure, pulses are single-cycle.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int N_BTN       = DEF_N_BTN,
  parameter int DB_CYCLES   = DEF_DB_CYCLES,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int RPT_CYCLES  = DEF_RPT_CYCLES
) (
  input  logic             CLK,
  input  logic             CPU_RESETN,
  input  logic [N_BTN-1:0] BTN_IN,
  output logic [N_BTN-1:0] BTN_LVL,
  output logic [N_BTN-1:0] BTN_PRESS,
  output logic [N_BTN-1:0] BTN_REL,
  output logic [N_BTN-1:0] BTN_RPT
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_channel #(
      .DB_CYCLES  (DB_CYCLES),
      .HOLD_CYCLES(HOLD_CYCLES),
      .RPT_CYCLES (RPT_CYCLES)
    ) u_ch (
      .clk    (CLK),
      .rst_n  (CPU_RESETN),
      .btn_raw(BTN_IN[i]),
      .lvl    (BTN_LVL[i]),
      .press  (BTN_PRESS[i]),
      .rel    (BTN_REL[i]),
      .rpt    (BTN_RPT[i])
    );
  end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter N_BTN, default 5: number of independent button channels (C, L, R, U, D).
REQ-002 SHALL have parameter DB_CYCLES, default 1_000_000: debounce stability window in CLK cycles (10 ms at 100 MHz); legal range >= 2.
REQ-003 SHALL have parameter HOLD_CYCLES, default 50_000_000: hold time before the first auto-repeat; SHALL be > DB_CYCLES.
REQ-004 SHALL have parameter RPT_CYCLES, default 10_000_000: auto-repeat period; legal range >= 2.
REQ-005 SHALL have port CLK, input, 1, the single system clock; all logic is in this one domain.
REQ-006 SHALL have port CPU_RESETN, input, 1, reset, asynchronous and active-low.
REQ-007 SHALL have port BTN_IN, input, N_BTN, raw asynchronous button levels (1 = pressed).
REQ-008 SHALL have port BTN_LVL, output, N_BTN, debounced level per channel.
REQ-009 SHALL have port BTN_PRESS, output, N_BTN, one-cycle pulse per accepted press.
REQ-010 SHALL have port BTN_REL, output, N_BTN, one-cycle pulse per accepted release.
REQ-011 SHALL have port BTN_RPT, output, N_BTN, one-cycle auto-repeat pulse while held.

Function
REQ-012 Each BTN_IN bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-013 Each channel SHALL run an independent FSM with four states: IDLE, DB_PRESS, DOWN, DB_REL.
REQ-014 IDLE: synced input = 1 -> DB_PRESS, with the debounce counter cleared to 0.
REQ-015 DB_PRESS: synced input = 0 -> IDLE with no output; the counter increments each cycle.
REQ-016 DB_PRESS: the clock edge with counter == DB_CYCLES-1 and synced input = 1 -> DOWN.
REQ-017 On entry to DOWN from DB_PRESS, BTN_PRESS SHALL be high for exactly one cycle and BTN_LVL SHALL go to 1.
REQ-018 Press latency: count the clock edge that first samples raw BTN_IN high as edge 1; BTN_PRESS SHALL be high in the cycle after edge DB_CYCLES+3.
REQ-019 DOWN: synced input = 0 -> DB_REL with the debounce counter cleared.
REQ-020 DB_REL: synced input = 1 -> DOWN with no pulse; the hold counter is not cleared.
REQ-021 DB_REL: the clock edge with counter == DB_CYCLES-1 and synced input = 0 -> IDLE, with BTN_REL high for one cycle and BTN_LVL going to 0.
REQ-022 Release latency SHALL equal press latency (DB_CYCLES+3 edges).
REQ-023 Hold counter: cleared on entry to DOWN from DB_PRESS; counts in DOWN and DB_REL.
REQ-024 BTN_RPT SHALL pulse HOLD_CYCLES cycles after the BTN_PRESS pulse, then every RPT_CYCLES cycles while the channel remains in DOWN or DB_REL.
REQ-025 BTN_PRESS, BTN_REL and BTN_RPT of one channel SHALL never be high in the same cycle.
REQ-026 Simultaneous events on different channels SHALL each produce their own pulses in the same cycle, with no arbitration.
REQ-027 All outputs SHALL be registered.
REQ-028 Counter widths SHALL be $clog2 of the largest governing parameter; counters SHALL never wrap mid-window.

Reset
REQ-029 CPU_RESETN low SHALL immediately, asynchronously, clear all outputs to 0, all FSMs to IDLE, and all counters and synchronizer flops to 0.
REQ-030 A button held through reset deassertion SHALL be treated as a new press: BTN_PRESS fires DB_CYCLES+3 edges after release of reset.
REQ-031 Reset asserted mid-debounce or mid-hold SHALL discard the pending event; no pulse SHALL be emitted.

Structure
REQ-032 State encodings (IDLE=0, DB_PRESS=1, DOWN=2, DB_REL=3) and default timing constants SHALL live in a shared package/include used by all consumers.
REQ-033 One sub-module, btn_channel (synchronizer + FSM + counters for one bit), SHALL be instantiated N_BTN times by a generate loop.

Verification (bench uses DB_CYCLES=4, HOLD_CYCLES=20, RPT_CYCLES=8)
REQ-034 Clean press on bit1, held 12 cycles, then released -> BTN_PRESS[1] one cycle after edge 7; BTN_LVL[1]=1; BTN_REL[1] one cycle 7 edges after release.
REQ-035 3-cycle glitch on bit2 -> no pulses; BTN_LVL[2] stays 0.
REQ-036 Bit3 held 50 cycles -> BTN_RPT[3] pulses at +20, +28, +36, +44 cycles after BTN_PRESS[3].
REQ-037 Bit0 in DOWN, 2-cycle low bounce -> no BTN_REL, no second BTN_PRESS; repeat timing unchanged.
REQ-038 Bits 0 and 4 rise in the same cycle -> BTN_PRESS = 5'b10001 in a single cycle.
REQ-039 Reset asserted during DB_PRESS with the button held -> outputs 0 immediately; BTN_PRESS 7 edges after reset release.
